// File: rtl/serial_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_byte_rx
//  Purpose  : UART-style oversampling byte receiver (8N1, or 8E1/8O1 when
//             SERIAL_RX_PARITY_EN is defined). Each good byte is presented on
//             Rx_Data one clock before a stretched RD strobe, so a downstream
//             stage can edge-detect RD and finish its RAM write.
//  Options  : SERIAL_RX_PARITY_EN - adds a parity bit after the data bits;
//             PARITY_ODD selects its sense (0 = even, 1 = odd).
//  Revision : 1.0 - initial release
// ============================================================================
module serial_byte_rx #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int RD_HIGH_CYCLES = 16,
    parameter bit PARITY_ODD     = 1'b0
) (
    input  logic       CLOCK_Digtal,
    input  logic       RST_n,
    input  logic       RXD,
    output logic       RD,
    output logic [7:0] Rx_Data,
    output logic       Frame_Err,
    output logic       Overrun_Err,
    output logic       Parity_Err,
    output logic       Busy
);

    // Half-bit point finds the middle of the start bit; full-bit steps
    // from there land in the middle of every following bit.
    localparam logic [15:0] c_HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_FULL_BIT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_RD_LAST  = 16'(RD_HIGH_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_LOAD   = 3'd5;
    localparam logic [2:0] c_ST_BREAK  = 3'd6;

    logic        sync1_q, sync2_q;
    logic        rxs;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_err_q, overrun_err_d;
    logic        parity_err_q, parity_err_d;
    logic        par_bad_q, par_bad_d;
    logic        busy_q, busy_d;
    logic        load_pend_q, load_pend_d;
    logic        rd_q;
    logic [15:0] rd_cnt_q;
    logic        w_bit_tick;
    logic        w_rd_active;

    assign rxs         = sync2_q;
    assign w_bit_tick  = (cnt_q == c_FULL_BIT);
    // A byte loaded last clock counts as active even before RD rises.
    assign w_rd_active = rd_q | load_pend_q;

`ifndef SERIAL_RX_PARITY_EN
    logic unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD;
`endif

    // Two-flop synchronizer; presets to the idle-high line level.
    always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RXD;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (!rxs) state_d = c_ST_START;
            end
            c_ST_START: begin
                if (cnt_q == c_HALF_BIT) state_d = rxs ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_tick && (bit_idx_q == 3'd7)) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = c_ST_PARITY;
`else
                    state_d = c_ST_STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_tick) state_d = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                if (w_bit_tick) begin
                    if (!rxs)          state_d = c_ST_BREAK;
                    else if (par_bad_q) state_d = c_ST_IDLE;
                    else               state_d = c_ST_LOAD;
                end
            end
            c_ST_LOAD:  state_d = c_ST_IDLE;
            // A held-low line must return high before a new start is accepted.
            c_ST_BREAK: begin
                if (rxs) state_d = c_ST_IDLE;
            end
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // Frame FSM outputs: bit timing, shifting, byte load and error pulses.
    always_comb begin
        cnt_d         = 16'd0;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        parity_err_d  = 1'b0;
        par_bad_d     = par_bad_q;
        load_pend_d   = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                bit_idx_d = 3'd0;
                par_bad_d = 1'b0;
            end
            c_ST_START: begin
                cnt_d = (cnt_q == c_HALF_BIT) ? 16'd0 : cnt_q + 16'd1;
            end
            c_ST_DATA: begin
                if (w_bit_tick) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_tick) begin
                    if (((^shift_q) ^ rxs) != PARITY_ODD) begin
                        parity_err_d = 1'b1;
                        par_bad_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_bit_tick) begin
                    frame_err_d = ~rxs;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            c_ST_LOAD: begin
                if (w_rd_active) begin
                    overrun_err_d = 1'b1;
                end else begin
                    rx_data_d   = shift_q;
                    load_pend_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
        busy_d = (state_d != c_ST_IDLE) && (state_d != c_ST_BREAK);
    end

    // Datapath and output pulse registers.
    always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q         <= 16'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
            rx_data_q     <= 8'd0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            par_bad_q     <= 1'b0;
            busy_q        <= 1'b0;
            load_pend_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            parity_err_q  <= parity_err_d;
            par_bad_q     <= par_bad_d;
            busy_q        <= busy_d;
            load_pend_q   <= load_pend_d;
        end
    end

    // RD stretcher: rises the clock after Rx_Data loads, high RD_HIGH_CYCLES clocks.
    always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
        if (!RST_n) begin
            rd_q     <= 1'b0;
            rd_cnt_q <= 16'd0;
        end else if (load_pend_q) begin
            rd_q     <= 1'b1;
            rd_cnt_q <= c_RD_LAST;
        end else if (rd_q) begin
            if (rd_cnt_q == 16'd0) begin
                rd_q <= 1'b0;
            end else begin
                rd_cnt_q <= rd_cnt_q - 16'd1;
            end
        end
    end

    assign RD          = rd_q;
    assign Rx_Data     = rx_data_q;
    assign Frame_Err   = frame_err_q;
    assign Overrun_Err = overrun_err_q;
    // Never set without the parity option, so it reads as constant 0 there.
    assign Parity_Err  = parity_err_q;
    assign Busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_byte_rx
//  Purpose  : Self-checking bench for serial_byte_rx; frames are modelled at
//             the byte level and DUT strobes are matched against the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_byte_rx;

    localparam int c_CPB     = 8;
    localparam int c_RDH     = 16;
    localparam int c_RDH_OVR = 100;
    localparam bit c_PODD    = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rxd;
    logic       rxd_ovr;
    logic       rd, fe, ov, pe, busy;
    logic [7:0] rx_data;
    logic       o_rd, o_fe, o_ov, o_pe, o_busy;
    logic [7:0] o_data;

    serial_byte_rx #(
        .CLKS_PER_BIT   (c_CPB),
        .RD_HIGH_CYCLES (c_RDH),
        .PARITY_ODD     (c_PODD)
    ) u_dut (
        .CLOCK_Digtal (clk),
        .RST_n        (rst_n),
        .RXD          (rxd),
        .RD           (rd),
        .Rx_Data      (rx_data),
        .Frame_Err    (fe),
        .Overrun_Err  (ov),
        .Parity_Err   (pe),
        .Busy         (busy)
    );

    serial_byte_rx #(
        .CLKS_PER_BIT   (c_CPB),
        .RD_HIGH_CYCLES (c_RDH_OVR),
        .PARITY_ODD     (c_PODD)
    ) u_dut_ovr (
        .CLOCK_Digtal (clk),
        .RST_n        (rst_n),
        .RXD          (rxd_ovr),
        .RD           (o_rd),
        .Rx_Data      (o_data),
        .Frame_Err    (o_fe),
        .Overrun_Err  (o_ov),
        .Parity_Err   (o_pe),
        .Busy         (o_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: byte-level expectations.
    logic [7:0] exp_q[$];
    int         exp_rd = 0, exp_fe = 0, exp_pe = 0;
    logic [7:0] last_good = 8'h00;

    // Observed counters from the monitors.
    int rd_rises = 0, fe_pulses = 0, pe_pulses = 0, ov_pulses = 0, busy_rises = 0;
    int o_rd_rises = 0, o_ov_pulses = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-level model: a frame yields a strobe only if stop and parity are good.
    task automatic model_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        logic par_ok;
        par_ok = !par_flip;
        if (!stop_v) exp_fe++;
        if (!par_ok) exp_pe++;
        if (stop_v && par_ok) begin
            exp_q.push_back(b);
            exp_rd++;
            last_good = b;
        end
    endtask

    task automatic drive_bit(input bit to_ovr, input logic v);
        if (to_ovr) rxd_ovr = v;
        else        rxd     = v;
        repeat (c_CPB) @(negedge clk);
    endtask

    task automatic send_frame(input bit to_ovr, input logic [7:0] b, input logic stop_v,
                              input logic par_flip);
        if (!to_ovr) model_frame(b, stop_v, par_flip);
        drive_bit(to_ovr, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(to_ovr, b[i]);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit(to_ovr, (^b) ^ c_PODD ^ par_flip);
`endif
        drive_bit(to_ovr, stop_v);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check_value($sformatf("%s_rd_count", tag), 32'(rd_rises), 32'(exp_rd));
        check_value($sformatf("%s_fe_count", tag), 32'(fe_pulses), 32'(exp_fe));
        check_value($sformatf("%s_pe_count", tag), 32'(pe_pulses), 32'(exp_pe));
        check_value($sformatf("%s_ov_count", tag), 32'(ov_pulses), 32'd0);
        check_value($sformatf("%s_pending", tag), 32'(exp_q.size()), 32'd0);
        check_value($sformatf("%s_rx_data", tag), 32'(rx_data), 32'(last_good));
    endtask

    // Main DUT monitor.
    logic       prev_rd = 1'b0, prev_busy = 1'b0, prev2_busy = 1'b0;
    logic       prev_fe = 1'b0, prev_pe = 1'b0, prev_ov = 1'b0;
    logic [7:0] prev_data = 8'h00, held = 8'h00, mon_exp;
    int         rd_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd    = 1'b0;
            prev_busy  = 1'b0;
            prev2_busy = 1'b0;
            prev_fe    = 1'b0;
            prev_pe    = 1'b0;
            prev_ov    = 1'b0;
            rd_len     = 0;
        end else begin
            if (rd && !prev_rd) begin
                rd_rises++;
                rd_len = 1;
                held   = rx_data;
                if (exp_q.size() == 0) begin
                    check_value("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_value("rd_data", 32'(rx_data), 32'(mon_exp));
                    check_value("data_setup", 32'(prev_data), 32'(mon_exp));
                    check_value("busy_fell_at_load", 32'({prev2_busy, prev_busy}), 32'b10);
                end
            end else if (rd) begin
                rd_len++;
                check_value("data_stable", 32'(rx_data), 32'(held));
            end else if (prev_rd) begin
                check_value("rd_width", 32'(rd_len), 32'(c_RDH));
                check_value("data_hold_after_rd", 32'(rx_data), 32'(held));
            end
            if (fe) begin
                if (!prev_fe) fe_pulses++;
                check_value("fe_one_clk", 32'(prev_fe), 32'd0);
            end
            if (pe) begin
                if (!prev_pe) pe_pulses++;
                check_value("pe_one_clk", 32'(prev_pe), 32'd0);
            end
            if (ov) begin
                if (!prev_ov) ov_pulses++;
            end
            if (busy && !prev_busy) busy_rises++;
            prev_rd    = rd;
            prev2_busy = prev_busy;
            prev_busy  = busy;
            prev_fe    = fe;
            prev_pe    = pe;
            prev_ov    = ov;
        end
        prev_data = rx_data;
    end

    // Overrun DUT monitor.
    logic o_prev_rd = 1'b0, o_prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rd && !o_prev_rd) o_rd_rises++;
            if (o_ov) begin
                if (!o_prev_ov) o_ov_pulses++;
                check_value("ovr_one_clk", 32'(o_prev_ov), 32'd0);
            end
            o_prev_rd = o_rd;
            o_prev_ov = o_ov;
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop_v, par_flip;
        int         gap;

        rst_n   = 1'b0;
        rxd     = 1'b1;
        rxd_ovr = 1'b1;
        repeat (3) @(negedge clk);
        check_value("reset_outputs", 32'({rd, busy, fe, ov, pe, rx_data}), 32'd0);
        rst_n = 1'b1;
        idle(6);
        check_value("idle_outputs", 32'({rd, busy, fe, ov, pe, rx_data}), 32'd0);

        // Single byte.
        send_frame(1'b0, 8'hA5, 1'b1, 1'b0);
        idle(30);
        check_counts("single");

        // Back-to-back bytes with no idle bits.
        send_frame(1'b0, 8'hEB, 1'b1, 1'b0);
        send_frame(1'b0, 8'h90, 1'b1, 1'b0);
        send_frame(1'b0, 8'h90, 1'b1, 1'b0);
        send_frame(1'b0, 8'hEB, 1'b1, 1'b0);
        idle(30);
        check_counts("b2b");

        // Short low glitch is rejected without errors.
        begin
            int b0;
            b0  = busy_rises;
            rxd = 1'b0;
            repeat (3) @(negedge clk);
            idle(20);
            check_value("glitch_busy_pulse", 32'(busy_rises - b0), 32'd1);
            check_value("glitch_busy_low", 32'(busy), 32'd0);
            check_counts("glitch");
        end

        // Bad stop bit followed by a long break, then a good byte.
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_value("busy_in_break", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check_value("break_rx_data", 32'(rx_data), 32'(last_good));
        idle(16);
        send_frame(1'b0, 8'h55, 1'b1, 1'b0);
        idle(30);
        check_counts("break");

        // Reset in the middle of data bit 4 of 0x7E.
        b = 8'h7E;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, b[i]);
        rxd = b[4];
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_value("midframe_reset_outputs", 32'({rd, busy, fe, ov, pe, rx_data}), 32'd0);
        last_good = 8'h00;
        rxd = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check_counts("reset_abort");
        send_frame(1'b0, 8'h7E, 1'b1, 1'b0);
        idle(30);
        check_counts("after_reset");

`ifdef SERIAL_RX_PARITY_EN
        // Even parity: 0x01 needs parity bit 1.
        send_frame(1'b0, 8'h01, 1'b1, 1'b0);
        idle(30);
        check_counts("parity_good");
        send_frame(1'b0, 8'h01, 1'b1, 1'b1);
        idle(30);
        check_counts("parity_bad");
`endif

        // Randomized traffic with occasional bad stop (and parity) bits.
        for (int n = 0; n < 24; n++) begin
            b        = 8'($urandom);
            stop_v   = ($urandom_range(0, 5) != 0);
            par_flip = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_flip = ($urandom_range(0, 5) == 0);
`endif
            send_frame(1'b0, b, stop_v, par_flip);
            if (!stop_v) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                idle(c_CPB + $urandom_range(0, 8));
            end else begin
                gap = $urandom_range(0, 2);
                idle(gap * c_CPB);
            end
        end
        idle(40);
        check_counts("random");

        // Overrun: second byte completes while the long RD is still high.
        send_frame(1'b1, 8'h12, 1'b1, 1'b0);
        send_frame(1'b1, 8'h34, 1'b1, 1'b0);
        repeat (110) @(negedge clk);
        check_value("ovr_rd_count", 32'(o_rd_rises), 32'd1);
        check_value("ovr_ov_count", 32'(o_ov_pulses), 32'd1);
        check_value("ovr_rx_data", 32'(o_data), 32'h12);
        send_frame(1'b1, 8'h56, 1'b1, 1'b0);
        repeat (110) @(negedge clk);
        check_value("ovr_rd_count2", 32'(o_rd_rises), 32'd2);
        check_value("ovr_ov_count2", 32'(o_ov_pulses), 32'd1);
        check_value("ovr_rx_data2", 32'(o_data), 32'h56);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
